axi_tohost_monitor: RTL and testbench

- Passive AXI write-channel snooper in the Ara test harness, between the SoC's system AXI bus and the harness `exit_o` consumed by the top-level bench.
- Observes AW/W handshakes and detects stores to the 64-bit `tohost` word.
- Produces the sticky `exit_o` end-of-computation code and the measured vector runtime.
- Never drives ready/valid; it has zero effect on bus timing.

---
 rtl/axi_tohost_pkg.sv | 27 ++
 rtl/aw_track_fifo.sv | 53 +++++
 rtl/axi_tohost_monitor.sv | 149 ++++++++++++++
 tb/tb_axi_tohost_monitor.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axi_tohost_pkg.sv
// rtl/axi_tohost_pkg.sv - shared types and helpers for the tohost write monitor
//
// Purpose: AW tracking record, tohost word size and the lane-index helper
// used by axi_tohost_monitor and aw_track_fifo.
package axi_tohost_pkg;

  // Size of the tohost word in bytes.
  localparam int unsigned ToHostBytes = 8;

  // Width of the burst length kept per tracked AW (covers AXI4 len).
  localparam int unsigned TrackLenWidth = 8;

  typedef struct packed {
    logic                     hit;
    logic [TrackLenWidth-1:0] len;
  } aw_track_t;

  // Index of the 64-bit lane of a bus_bytes-wide data bus that holds the
  // 8-byte word containing addr.
  function automatic int unsigned tohost_lane(input logic [63:0] addr,
                                              input int unsigned bus_bytes);
    int unsigned w_low;
    w_low = int'({16'd0, addr[15:0]});
    return (w_low % bus_bytes) / ToHostBytes;
  endfunction

endpackage

// File: rtl/aw_track_fifo.sv
// rtl/aw_track_fifo.sv - queue of outstanding AW records awaiting W data
//
// Purpose: plain registered FIFO of aw_track_t, no fall-through.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  write one record (caller guarantees not full unless popping)
//   pop_i          drop the head record (caller guarantees not empty)
//   data_o         current head record
//   full_o/empty_o queue status
module aw_track_fifo
  import axi_tohost_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      push_i,
  input  aw_track_t data_i,
  input  logic      pop_i,
  output aw_track_t data_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0] r_wptr;
  logic [PtrW-1:0] r_rptr;
  aw_track_t       r_mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (push_i) r_wptr <= r_wptr + PtrW'(1);
      if (pop_i)  r_rptr <= r_rptr + PtrW'(1);
    end
  end

  // Storage needs no reset: it is only read when the pointers say it is valid.
  always_ff @(posedge clk_i) begin
    if (push_i) r_mem[r_wptr[AddrW-1:0]] <= data_i;
  end

  assign data_o  = r_mem[r_rptr[AddrW-1:0]];
  assign empty_o = (r_wptr == r_rptr);
  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign full_o  = (r_wptr[AddrW] != r_rptr[AddrW]) &&
                   (r_wptr[AddrW-1:0] == r_rptr[AddrW-1:0]);

endmodule

// File: rtl/axi_tohost_monitor.sv
// rtl/axi_tohost_monitor.sv - passive AXI write snooper producing exit code and runtime
//
// Purpose: watches AW/W handshakes, shadows stores to the 64-bit tohost word
// and raises a sticky exit code once a store sets bit 0. Never drives the bus.
// Optional macro TOHOST_MON_CYCLE_CNT_EN enables the cnt_en_i window counter;
// without it runtime_o is tied to zero.
// Ports:
//   clk_i, rst_ni               clock, asynchronous active-low reset
//   aw_valid_i/aw_ready_i       AW handshake, aw_addr_i/aw_len_i AW payload
//   w_valid_i/w_ready_i         W handshake, w_data_i/w_strb_i/w_last_i W payload
//   cnt_en_i                    runtime window enable
//   exit_o                      {code, done}, frozen once bit 0 is set
//   runtime_o                   length of the last cnt_en_i window in cycles
//   proto_err_o                 sticky AXI write protocol error
module axi_tohost_monitor
  import axi_tohost_pkg::*;
#(
  parameter int unsigned AxiAddrWidth   = 64,
  parameter int unsigned AxiDataWidth   = 128,
  parameter int unsigned AxiLenWidth    = 8,
  parameter logic [63:0] ToHostAddr     = 64'h8000_1000,
  parameter int unsigned MaxOutstanding = 4,
  parameter int unsigned CntWidth       = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      aw_valid_i,
  input  logic                      aw_ready_i,
  input  logic [AxiAddrWidth-1:0]   aw_addr_i,
  input  logic [AxiLenWidth-1:0]    aw_len_i,
  input  logic                      w_valid_i,
  input  logic                      w_ready_i,
  input  logic [AxiDataWidth-1:0]   w_data_i,
  input  logic [AxiDataWidth/8-1:0] w_strb_i,
  input  logic                      w_last_i,
  input  logic                      cnt_en_i,
  output logic [63:0]               exit_o,
  output logic [CntWidth-1:0]       runtime_o,
  output logic                      proto_err_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned LaneIdx   = tohost_lane(ToHostAddr, StrbWidth);

  logic                     w_aw_hs, w_w_hs;
  logic                     w_fifo_empty, w_fifo_full;
  logic                     w_bypass, w_have_head, w_push, w_pop;
  logic                     w_orphan, w_aw_overflow, w_last_err, w_hit_beat;
  aw_track_t                w_aw_entry, w_fifo_head, w_head;
  logic [63:0]              w_lane_data, w_shadow_nxt;
  logic [7:0]               w_lane_strb;
  logic [TrackLenWidth-1:0] r_beat_cnt;
  logic [63:0]              r_shadow, r_exit;
  logic                     r_proto_err;
  logic                     w_unused;

  assign w_aw_hs = aw_valid_i & aw_ready_i;
  assign w_w_hs  = w_valid_i & w_ready_i;

  assign w_aw_entry.hit = (aw_addr_i[AxiAddrWidth-1:3] == ToHostAddr[AxiAddrWidth-1:3]);
  assign w_aw_entry.len = TrackLenWidth'(aw_len_i);

  // An AW arriving with a beat on an empty queue acts as the head directly.
  assign w_bypass    = w_w_hs & w_aw_hs & w_fifo_empty;
  assign w_have_head = ~w_fifo_empty | w_bypass;
  assign w_head      = w_bypass ? w_aw_entry : w_fifo_head;

  assign w_orphan      = w_w_hs & ~w_have_head;
  assign w_pop         = w_w_hs & w_last_i & ~w_fifo_empty;
  assign w_aw_overflow = w_aw_hs & w_fifo_full & ~w_pop;
  // A bypassed single-beat burst completes at once and is never queued.
  assign w_push        = w_aw_hs & ~w_aw_overflow & ~(w_bypass & w_last_i);
  assign w_last_err    = w_w_hs & w_have_head & (w_last_i != (r_beat_cnt == w_head.len));
  assign w_hit_beat    = w_w_hs & w_have_head & w_head.hit & (r_beat_cnt == '0);

  assign w_lane_data = w_data_i[LaneIdx*64 +: 64];
  assign w_lane_strb = w_strb_i[LaneIdx*8 +: 8];

  always_comb begin
    w_shadow_nxt = r_shadow;
    for (int k = 0; k < ToHostBytes; k++) begin
      if (w_lane_strb[k]) w_shadow_nxt[8*k +: 8] = w_lane_data[8*k +: 8];
    end
  end

  aw_track_fifo #(
    .Depth(MaxOutstanding)
  ) u_aw_track_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (w_push),
    .data_i (w_aw_entry),
    .pop_i  (w_pop),
    .data_o (w_fifo_head),
    .full_o (w_fifo_full),
    .empty_o(w_fifo_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_beat_cnt  <= '0;
      r_shadow    <= '0;
      r_exit      <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_w_hs && w_have_head) begin
        r_beat_cnt <= w_last_i ? '0 : r_beat_cnt + TrackLenWidth'(1);
      end
      if (w_hit_beat) r_shadow <= w_shadow_nxt;
      if (w_hit_beat && w_shadow_nxt[0] && !r_exit[0]) r_exit <= w_shadow_nxt;
      if (w_orphan || w_aw_overflow || w_last_err) r_proto_err <= 1'b1;
    end
  end

  assign exit_o      = r_exit;
  assign proto_err_o = r_proto_err;

  // Bits outside the tohost lane and the sub-word address are intentionally ignored.
  assign w_unused = ^{aw_addr_i[2:0], w_data_i, w_strb_i};

`ifdef TOHOST_MON_CYCLE_CNT_EN
  logic                r_cnt_en_q;
  logic [CntWidth-1:0] r_cnt;
  logic [CntWidth-1:0] r_runtime;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt_en_q <= 1'b0;
      r_cnt      <= '0;
      r_runtime  <= '0;
    end else begin
      r_cnt_en_q <= cnt_en_i;
      if (cnt_en_i && !r_cnt_en_q) begin
        r_cnt <= CntWidth'(1);
      end else if (cnt_en_i && !(&r_cnt)) begin
        r_cnt <= r_cnt + CntWidth'(1);
      end
      if (!cnt_en_i && r_cnt_en_q) r_runtime <= r_cnt;
    end
  end

  assign runtime_o = r_runtime;
`else
  logic w_unused_cnt_en;
  assign w_unused_cnt_en = cnt_en_i;
  assign runtime_o       = '0;
`endif

endmodule

// File: tb/tb_axi_tohost_monitor.sv
// tb/tb_axi_tohost_monitor.sv - directed self-checking bench for axi_tohost_monitor
module tb_axi_tohost_monitor;

  localparam logic [63:0] TA = 64'h8000_1000;
  localparam logic [63:0] NH = 64'h8000_2000;
  localparam logic [63:0] NL = 64'h8000_1008;
  localparam logic [63:0] UPPER = 64'hFFFF_FFFF_FFFF_FFFF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         aw_valid = 1'b0, aw_ready = 1'b0;
  logic [63:0]  aw_addr = '0;
  logic [7:0]   aw_len = '0;
  logic         w_valid = 1'b0, w_ready = 1'b0, w_last = 1'b0;
  logic [127:0] w_data = '0;
  logic [15:0]  w_strb = '0;
  logic         cnt_en = 1'b0;
  logic [63:0]  exit_v;
  logic [63:0]  runtime;
  logic         proto_err;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_tohost_monitor dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .aw_valid_i (aw_valid),
    .aw_ready_i (aw_ready),
    .aw_addr_i  (aw_addr),
    .aw_len_i   (aw_len),
    .w_valid_i  (w_valid),
    .w_ready_i  (w_ready),
    .w_data_i   (w_data),
    .w_strb_i   (w_strb),
    .w_last_i   (w_last),
    .cnt_en_i   (cnt_en),
    .exit_o     (exit_v),
    .runtime_o  (runtime),
    .proto_err_o(proto_err)
  );

  typedef struct {
    bit          rst;
    bit          awv;
    bit          awr;
    logic [63:0] addr;
    logic [7:0]  len;
    bit          wv;
    bit          wr;
    logic [63:0] data;
    logic [15:0] strb;
    bit          last;
    logic [63:0] exp_exit;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit awv, bit awr, logic [63:0] addr, logic [7:0] len,
                              bit wv, bit wr, logic [63:0] data, logic [15:0] strb, bit last,
                              logic [63:0] ee, bit er);
    vec_t v;
    v.rst = rst; v.awv = awv; v.awr = awr; v.addr = addr; v.len = len;
    v.wv = wv; v.wr = wr; v.data = data; v.strb = strb; v.last = last;
    v.exp_exit = ee; v.exp_err = er;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit awv, input bit awr, input logic [63:0] addr, input logic [7:0] len,
                       input bit wv, input bit wr, input logic [63:0] data, input logic [15:0] strb,
                       input bit last);
    aw_valid = awv; aw_ready = awr; aw_addr = addr; aw_len = len;
    w_valid = wv; w_ready = wr; w_data = {UPPER, data}; w_strb = strb; w_last = last;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, '0, '0, 0, 0, '0, '0, 0);
    cnt_en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("reset exit", exit_v, 64'd0);
    chk("reset err", {63'd0, proto_err}, 64'd0);
    chk("reset runtime", runtime, 64'd0);
    rst_n = 1'b1;
  endtask

  // One full-strobe cycle with both readies high; outputs sampled 1 after the edge.
  task automatic cyc(input bit awv, input logic [63:0] addr, input logic [7:0] len,
                     input bit wv, input logic [63:0] data, input bit last);
    @(negedge clk);
    drive(awv, 1, addr, len, wv, 1, data, 16'hFFFF, last);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Partial strobes accumulate in the shadow
    vecs.push_back(mk(1, 1, 1, TA, 0, 1, 1, 64'h10, 16'h000F, 1, 64'h0, 0));
    vecs.push_back(mk(0, 1, 1, TA, 0, 1, 1, 64'h11, 16'h0001, 1, 64'h11, 0));
    // Exit sticky once done
    vecs.push_back(mk(1, 1, 1, TA, 0, 0, 1, 64'h0, 16'h0000, 0, 64'h0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 0, 1, 1, 64'h7, 16'hFFFF, 1, 64'h7, 0));
    vecs.push_back(mk(0, 1, 1, TA, 0, 1, 1, 64'h9, 16'hFFFF, 1, 64'h7, 0));
    // Plain single-beat store
    vecs.push_back(mk(1, 1, 1, TA, 0, 1, 1, 64'h1, 16'hFFFF, 1, 64'h1, 0));
    // Strobe masking excludes byte 0, then byte 0 completes it
    vecs.push_back(mk(1, 1, 1, TA, 0, 1, 1, 64'h0101, 16'h0002, 1, 64'h0, 0));
    vecs.push_back(mk(0, 1, 1, TA, 0, 1, 1, 64'h0001, 16'h0001, 1, 64'h0101, 0));
    // Neighbouring word misses; sub-word address inside tohost hits
    vecs.push_back(mk(1, 1, 1, NL, 0, 1, 1, 64'h1, 16'hFFFF, 1, 64'h0, 0));
    vecs.push_back(mk(0, 1, 1, TA + 4, 0, 1, 1, 64'h3, 16'hFFFF, 1, 64'h3, 0));
    // Orphan W, then normal store still works
    vecs.push_back(mk(1, 0, 1, 64'h0, 0, 1, 1, 64'h1, 16'hFFFF, 1, 64'h0, 1));
    vecs.push_back(mk(0, 1, 1, TA, 0, 1, 1, 64'h5, 16'hFFFF, 1, 64'h5, 1));
    // AW without ready is not a handshake
    vecs.push_back(mk(1, 1, 0, TA, 0, 0, 1, 64'h0, 16'h0000, 0, 64'h0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 0, 1, 1, 64'h1, 16'hFFFF, 1, 64'h0, 1));
    // W without ready is not a handshake
    vecs.push_back(mk(1, 1, 1, TA, 0, 0, 1, 64'h0, 16'h0000, 0, 64'h0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 0, 1, 0, 64'h1, 16'hFFFF, 1, 64'h0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 0, 1, 1, 64'h1, 16'hFFFF, 1, 64'h1, 0));
    // Early last on a len=1 burst
    vecs.push_back(mk(1, 1, 1, TA, 1, 1, 1, 64'h21, 16'hFFFF, 1, 64'h21, 1));
    // Missing last on a len=0 burst
    vecs.push_back(mk(1, 1, 1, TA, 0, 1, 1, 64'h3, 16'hFFFF, 0, 64'h3, 1));
    // Bypassed first beat of a 2-beat burst; beat 1 ignored; then queue empty
    vecs.push_back(mk(1, 1, 1, TA, 1, 1, 1, 64'h0E, 16'hFFFF, 0, 64'h0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 0, 1, 1, 64'hFF, 16'hFFFF, 1, 64'h0, 0));
    vecs.push_back(mk(0, 0, 1, 64'h0, 0, 1, 1, 64'h1, 16'hFFFF, 1, 64'h0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) do_reset();
      @(negedge clk);
      drive(vecs[i].awv, vecs[i].awr, vecs[i].addr, vecs[i].len, vecs[i].wv, vecs[i].wr,
            vecs[i].data, vecs[i].strb, vecs[i].last);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d exit", i), exit_v, vecs[i].exp_exit);
      chk($sformatf("vec%0d err", i), {63'd0, proto_err}, {63'd0, vecs[i].exp_err});
    end

    // Four outstanding AWs, delayed W stream of 13 beats, push during pop at full
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, NH, 8'd3, 0, 64'h0, 0);
    cyc(1, TA, 8'd0, 0, 64'h0, 0);
    chk("queue fill err", {63'd0, proto_err}, 64'd0);
    repeat (10) cyc(0, 64'h0, 8'd0, 0, 64'h0, 0);
    for (int b = 0; b < 13; b++) begin
      cyc(b == 3, NH, 8'd0, 1, (b == 12) ? 64'h4B : 64'h1, (b == 12) ? 1'b1 : ((b % 4) == 3));
      chk($sformatf("beat%0d exit", b), exit_v, (b == 12) ? 64'h4B : 64'h0);
      if (b == 3) chk("push at full err", {63'd0, proto_err}, 64'd0);
    end
    chk("burst end err", {63'd0, proto_err}, 64'd0);
    // One entry left; three more fill it, a fifth overflows
    for (int i = 0; i < 3; i++) cyc(1, NH, 8'd0, 0, 64'h0, 0);
    chk("full no err", {63'd0, proto_err}, 64'd0);
    cyc(1, TA, 8'd0, 0, 64'h0, 0);
    chk("overflow err", {63'd0, proto_err}, 64'd1);
    chk("overflow exit", exit_v, 64'h4B);

    // Reset in the middle of a burst
    do_reset();
    cyc(1, TA, 8'd3, 0, 64'h0, 0);
    cyc(0, 64'h0, 8'd0, 1, 64'h10, 0);
    do_reset();
    cyc(0, 64'h0, 8'd0, 1, 64'h1, 1);
    chk("post-reset orphan err", {63'd0, proto_err}, 64'd1);
    chk("post-reset orphan exit", exit_v, 64'd0);

`ifdef TOHOST_MON_CYCLE_CNT_EN
    do_reset();
    @(negedge clk);
    cnt_en = 1'b1;
    repeat (250) @(negedge clk);
    cnt_en = 1'b0;
    chk("runtime before drop", runtime, 64'd0);
    @(posedge clk);
    #1;
    chk("runtime 250", runtime, 64'd250);
    repeat (5) @(negedge clk);
    cnt_en = 1'b1;
    repeat (40) @(negedge clk);
    cnt_en = 1'b0;
    chk("runtime hold", runtime, 64'd250);
    @(posedge clk);
    #1;
    chk("runtime 40", runtime, 64'd40);
`else
    do_reset();
    @(negedge clk);
    cnt_en = 1'b1;
    repeat (20) @(negedge clk);
    cnt_en = 1'b0;
    @(posedge clk);
    #1;
    chk("runtime tied", runtime, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
